// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: event sources from the pipeline and
// the stall/flush/jump/divider control returned by the arbiter.
interface pipe_hazard_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5
);
    logic              hold_i;
    logic              ex_jump_i;
    logic [ADDR_W-1:0] ex_jump_addr_i;
    logic              ex_load_i;
    logic [REG_AW-1:0] ex_rd_addr_i;
    logic [REG_AW-1:0] id_rs1_addr_i;
    logic [REG_AW-1:0] id_rs2_addr_i;
    logic              id_rs1_re_i;
    logic              id_rs2_re_i;
    logic              ex_div_i;
    logic              div_done_i;
    logic [3:0]        stall_o;
    logic [2:0]        flush_o;
    logic              jump_ena_o;
    logic [ADDR_W-1:0] jump_addr_o;
    logic              div_start_o;
    logic              div_err_o;

    modport master (
        output hold_i, ex_jump_i, ex_jump_addr_i, ex_load_i, ex_rd_addr_i,
               id_rs1_addr_i, id_rs2_addr_i, id_rs1_re_i, id_rs2_re_i,
               ex_div_i, div_done_i,
        input  stall_o, flush_o, jump_ena_o, jump_addr_o, div_start_o, div_err_o
    );

    modport slave (
        input  hold_i, ex_jump_i, ex_jump_addr_i, ex_load_i, ex_rd_addr_i,
               id_rs1_addr_i, id_rs2_addr_i, id_rs1_re_i, id_rs2_re_i,
               ex_div_i, div_done_i,
        output stall_o, flush_o, jump_ena_o, jump_addr_o, div_start_o, div_err_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard arbiter for the 5-stage core: resolves hold, divide, jump and load-use
// into stall/flush vectors, sequences the divider and replays deferred jumps.
module pipe_hazard_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int REG_AW      = 5,
    parameter int DIV_TIMEOUT = 64
) (
    input logic               clk_100MHz,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_WAIT = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    div_state_t        state_r;
    div_state_t        state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              err_r;
    logic              jp_v_r;
    logic [ADDR_W-1:0] jp_addr_r;

    logic              timeout_s;
    logic              div_stall_s;
    logic              load_use_s;
    logic              jump_req_s;
    logic              jump_issue_s;
    logic              jp_capture_s;
    logic [REG_AW-1:0] rd_s;
    logic [3:0]        stall_s;
    logic [2:0]        flush_s;
    logic              jump_ena_s;
    logic [ADDR_W-1:0] jump_addr_s;
    logic              div_start_s;

    assign rd_s       = bus.ex_rd_addr_i;
    assign timeout_s  = (state_r == DIV_WAIT) && !bus.div_done_i && (cnt_r == CNT_LAST);
    assign load_use_s = bus.ex_load_i && (rd_s != {REG_AW{1'b0}}) &&
                        ((bus.id_rs1_re_i && (bus.id_rs1_addr_i == rd_s)) ||
                         (bus.id_rs2_re_i && (bus.id_rs2_addr_i == rd_s)));
    // A held jump is the same EX instruction, so a live request is ignored while one is pending.
    assign jump_req_s   = jp_v_r || bus.ex_jump_i;
    assign jump_issue_s = !rst && !bus.hold_i && !div_stall_s && jump_req_s;
    assign jp_capture_s = !jp_v_r && bus.ex_jump_i && (bus.hold_i || div_stall_s);

    // Divider-related stall request for the current state.
    always_comb begin
        div_stall_s = 1'b0;
        case (state_r)
            DIV_IDLE: div_stall_s = bus.ex_div_i;
            DIV_WAIT: div_stall_s = !bus.div_done_i && !timeout_s;
            DIV_DONE: div_stall_s = bus.hold_i;
            default:  div_stall_s = 1'b0;
        endcase
    end

    // Divider FSM state register.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state_r <= DIV_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Divider FSM next-state logic; a done seen under hold is parked in DONE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            DIV_IDLE: begin
                if (bus.ex_div_i && !bus.hold_i) state_nxt_s = DIV_WAIT;
                else                             state_nxt_s = DIV_IDLE;
            end
            DIV_WAIT: begin
                if (bus.div_done_i)  state_nxt_s = bus.hold_i ? DIV_DONE : DIV_IDLE;
                else if (timeout_s)  state_nxt_s = DIV_IDLE;
                else                 state_nxt_s = DIV_WAIT;
            end
            DIV_DONE: begin
                if (!bus.hold_i) state_nxt_s = DIV_IDLE;
                else             state_nxt_s = DIV_DONE;
            end
            default: state_nxt_s = DIV_IDLE;
        endcase
    end

    // Wait-cycle counter: zero outside WAIT, counts every WAIT cycle including held ones.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else if ((state_r == DIV_WAIT) && (state_nxt_s == DIV_WAIT)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= CNT_ZERO;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Pending-jump register: captures a blocked jump, releases it when it issues.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            jp_v_r    <= 1'b0;
            jp_addr_r <= {ADDR_W{1'b0}};
        end else if (jp_v_r && jump_issue_s) begin
            jp_v_r    <= 1'b0;
            jp_addr_r <= jp_addr_r;
        end else if (jp_capture_s) begin
            jp_v_r    <= 1'b1;
            jp_addr_r <= bus.ex_jump_addr_i;
        end else begin
            jp_v_r    <= jp_v_r;
            jp_addr_r <= jp_addr_r;
        end
    end

    // Prioritised stall/flush/jump outputs; combinational so hazards act in the same cycle.
    always_comb begin
        stall_s     = 4'b0000;
        flush_s     = 3'b000;
        jump_ena_s  = 1'b0;
        jump_addr_s = bus.ex_jump_addr_i;
        div_start_s = 1'b0;
        if (rst) begin
            flush_s = 3'b111;
        end else if (bus.hold_i) begin
            stall_s = 4'b1111;
        end else if (div_stall_s) begin
            stall_s     = 4'b0111;
            flush_s     = 3'b100;
            div_start_s = (state_r == DIV_IDLE);
        end else if (jump_req_s) begin
            jump_ena_s  = 1'b1;
            jump_addr_s = jp_v_r ? jp_addr_r : bus.ex_jump_addr_i;
            flush_s     = 3'b011;
        end else if (load_use_s) begin
            stall_s = 4'b0011;
            flush_s = 3'b010;
        end else begin
            stall_s = 4'b0000;
        end
    end

    assign bus.stall_o     = stall_s;
    assign bus.flush_o     = flush_s;
    assign bus.jump_ena_o  = jump_ena_s;
    assign bus.jump_addr_o = jump_addr_s;
    assign bus.div_start_o = div_start_s;
    assign bus.div_err_o   = err_r;
endmodule
